// File: rtl/dnn_mlp_seq.sv
// Two-layer MLP (N_IN -> N_HID ReLU -> N_OUT linear). One shared MAC is time-multiplexed
// over both layers, and the operands are captured when the job is accepted.
module dnn_mlp_seq #(
    parameter int N_IN  = 4,
    parameter int N_HID = 4,
    parameter int N_OUT = 2,
    parameter int DW    = 5,
    parameter int HW    = 11,
    parameter int OW    = 17
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_IN*DW-1:0]         x_flat,
    input  logic [N_IN*N_HID*DW-1:0]   w1_flat,
    input  logic [N_HID*N_OUT*DW-1:0]  w2_flat,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_OUT*OW-1:0]        out_flat
);
    // The accumulator must hold full layer-1 and layer-2 sums and also cover both clamp ranges.
    localparam int A1  = 2*DW + $clog2(N_IN) + 1;
    localparam int A2  = HW + DW + $clog2(N_HID) + 1;
    localparam int A12 = (A1 > A2) ? A1 : A2;
    localparam int A3  = (OW > HW) ? OW + 1 : HW + 1;
    localparam int AW  = (A12 > A3) ? A12 : A3;
    localparam int NM1 = (N_IN > N_HID) ? N_IN : N_HID;
    localparam int NMX = (NM1 > N_OUT) ? NM1 : N_OUT;
    localparam int CW  = $clog2(NMX) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_L1   = 2'd1;
    localparam logic [1:0] S_L2   = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]                    state_q, state_d;
    logic [CW-1:0]                 inner_q, inner_d, outer_q, outer_d;
    logic signed [AW-1:0]          acc_q, acc_d;
    logic [N_IN*DW-1:0]            x_q, x_d;
    logic [N_IN*N_HID*DW-1:0]      w1_q, w1_d;
    logic [N_HID*N_OUT*DW-1:0]     w2_q, w2_d;
    logic [N_HID*HW-1:0]           h_q, h_d;
    logic [N_OUT*OW-1:0]           out_q, out_d;

    logic signed [DW-1:0]          x_sel, w_sel;
    logic signed [HW-1:0]          h_sel;
    logic signed [AW-1:0]          a_ext, b_ext, mac, sat_h, sat_o;
    logic                          last_in, last_out;
    int                            ii, oi;

    function automatic logic signed [AW-1:0] sat(input logic signed [AW-1:0] v, input int w);
        logic signed [AW-1:0] mx, mn;
        mx = (AW'(1) << (w - 1)) - AW'(1);
        mn = ~mx;
        if (v > mx)      return mx;
        else if (v < mn) return mn;
        else             return v;
    endfunction

    always_comb begin
        ii      = int'(inner_q);
        oi      = int'(outer_q);
        x_sel   = '0;
        w_sel   = '0;
        h_sel   = '0;
        a_ext   = '0;
        b_ext   = '0;
        if (state_q == S_L1) begin
            x_sel = x_q[ii*DW +: DW];
            w_sel = w1_q[(oi*N_IN + ii)*DW +: DW];
            a_ext = AW'(x_sel);
            b_ext = AW'(w_sel);
        end else if (state_q == S_L2) begin
            h_sel = h_q[ii*HW +: HW];
            w_sel = w2_q[(oi*N_HID + ii)*DW +: DW];
            a_ext = AW'(h_sel);
            b_ext = AW'(w_sel);
        end
        mac   = acc_q + a_ext * b_ext;
        sat_h = sat(mac, HW);
        sat_o = sat(mac, OW);

        state_d  = state_q;
        inner_d  = inner_q;
        outer_d  = outer_q;
        acc_d    = acc_q;
        x_d      = x_q;
        w1_d     = w1_q;
        w2_d     = w2_q;
        h_d      = h_q;
        out_d    = out_q;
        last_in  = 1'b0;
        last_out = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d     = x_flat;
                    w1_d    = w1_flat;
                    w2_d    = w2_flat;
                    inner_d = '0;
                    outer_d = '0;
                    acc_d   = '0;
                    state_d = S_L1;
                end
            end
            S_L1: begin
                acc_d    = mac;
                last_in  = (inner_q == CW'(N_IN - 1));
                last_out = (outer_q == CW'(N_HID - 1));
                if (last_in) begin
                    h_d[oi*HW +: HW] = sat_h[AW-1] ? '0 : sat_h[HW-1:0];
                    acc_d   = '0;
                    inner_d = '0;
                    outer_d = last_out ? '0 : outer_q + CW'(1);
                    if (last_out) state_d = S_L2;
                end else begin
                    inner_d = inner_q + CW'(1);
                end
            end
            S_L2: begin
                acc_d    = mac;
                last_in  = (inner_q == CW'(N_HID - 1));
                last_out = (outer_q == CW'(N_OUT - 1));
                if (last_in) begin
                    out_d[oi*OW +: OW] = sat_o[OW-1:0];
                    acc_d   = '0;
                    inner_d = '0;
                    outer_d = last_out ? '0 : outer_q + CW'(1);
                    if (last_out) state_d = S_HOLD;
                end else begin
                    inner_d = inner_q + CW'(1);
                end
            end
            default: begin
                if (out_ready) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            inner_q <= '0;
            outer_q <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            w1_q    <= '0;
            w2_q    <= '0;
            h_q     <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            inner_q <= inner_d;
            outer_q <= outer_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            h_q     <= h_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE) && rst_n;
    assign out_valid = (state_q == S_HOLD);
    assign out_flat  = out_q;
endmodule

// File: tb/tb_dnn_mlp_seq.sv
// Testbench for dnn_mlp_seq: a default instance plus an OW=12 instance, both checked
// against an integer reference model of the network.
module tb_dnn_mlp_seq;
    localparam int N_IN = 4, N_HID = 4, N_OUT = 2, DW = 5, HW = 11, OW = 17, OW2 = 12;
    localparam int XW = N_IN*DW, W1W = N_IN*N_HID*DW, W2W = N_HID*N_OUT*DW;
    localparam int LAT = N_IN*N_HID + N_HID*N_OUT;

    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [XW-1:0] x_flat = '0;
    logic [W1W-1:0] w1_flat = '0;
    logic [W2W-1:0] w2_flat = '0;
    logic in_ready, out_valid, in_ready2, out_valid2;
    logic [N_OUT*OW-1:0] out_flat;
    logic [N_OUT*OW2-1:0] out_flat2;

    int tests = 0, fails = 0;
    int xa[N_IN];
    int w1a[N_IN][N_HID];
    int w2a[N_HID][N_OUT];

    always #5 clk = ~clk;

    dnn_mlp_seq #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .DW(DW), .HW(HW), .OW(OW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x_flat(x_flat), .w1_flat(w1_flat), .w2_flat(w2_flat),
        .out_valid(out_valid), .out_ready(out_ready), .out_flat(out_flat));

    dnn_mlp_seq #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .DW(DW), .HW(HW), .OW(OW2)) dut12 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .x_flat(x_flat), .w1_flat(w1_flat), .w2_flat(w2_flat),
        .out_valid(out_valid2), .out_ready(out_ready), .out_flat(out_flat2));

    function automatic int clamp(input int v, input int w);
        int mx, mn;
        mx = (1 << (w - 1)) - 1;
        mn = -(1 << (w - 1));
        return (v > mx) ? mx : (v < mn) ? mn : v;
    endfunction

    function automatic int model(input int k, input int ow);
        int h[N_HID];
        int s;
        for (int j = 0; j < N_HID; j++) begin
            s = 0;
            for (int i = 0; i < N_IN; i++) s += xa[i] * w1a[i][j];
            h[j] = clamp(s, HW);
            if (h[j] < 0) h[j] = 0;
        end
        s = 0;
        for (int j = 0; j < N_HID; j++) s += h[j] * w2a[j][k];
        return clamp(s, ow);
    endfunction

    function automatic int got(input int k);
        logic signed [OW-1:0] v;
        v = out_flat[k*OW +: OW];
        return int'(v);
    endfunction

    function automatic int got12(input int k);
        logic signed [OW2-1:0] v;
        v = out_flat2[k*OW2 +: OW2];
        return int'(v);
    endfunction

    task automatic fill(input int xv, input int w1v, input int w2v, input bit rnd);
        for (int i = 0; i < N_IN; i++) xa[i] = rnd ? int'($urandom_range(0, 31)) - 16 : xv;
        for (int i = 0; i < N_IN; i++)
            for (int j = 0; j < N_HID; j++) w1a[i][j] = rnd ? int'($urandom_range(0, 31)) - 16 : w1v;
        for (int j = 0; j < N_HID; j++)
            for (int k = 0; k < N_OUT; k++) w2a[j][k] = rnd ? int'($urandom_range(0, 31)) - 16 : w2v;
        for (int i = 0; i < N_IN; i++) x_flat[i*DW +: DW] = xa[i][DW-1:0];
        for (int i = 0; i < N_IN; i++)
            for (int j = 0; j < N_HID; j++) w1_flat[(j*N_IN+i)*DW +: DW] = w1a[i][j][DW-1:0];
        for (int j = 0; j < N_HID; j++)
            for (int k = 0; k < N_OUT; k++) w2_flat[(k*N_HID+j)*DW +: DW] = w2a[j][k][DW-1:0];
    endtask

    // Accept a job, then scramble the input buses so a missing capture shows up.
    task automatic start_job();
        int n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        tests++;
        if (!in_ready) begin fails++; $display("FAIL start: in_ready=%0b want 1", in_ready); end
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        x_flat  = XW'({$urandom, $urandom});
        w1_flat = W1W'({$urandom, $urandom, $urandom});
        w2_flat = W2W'({$urandom, $urandom});
    endtask

    task automatic wait_done(input string name);
        int lat = 0;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        tests++;
        if (lat != LAT || !out_valid) begin
            fails++; $display("FAIL %s latency: got %0d want %0d", name, lat, LAT);
        end
    endtask

    task automatic check_out(input string name);
        for (int k = 0; k < N_OUT; k++) begin
            tests++;
            if (got(k) !== model(k, OW)) begin
                fails++; $display("FAIL %s out[%0d]: got %0d want %0d", name, k, got(k), model(k, OW));
            end
            tests++;
            if (got12(k) !== model(k, OW2)) begin
                fails++; $display("FAIL %s out12[%0d]: got %0d want %0d", name, k, got12(k), model(k, OW2));
            end
        end
    endtask

    task automatic release_out(input string name);
        logic [N_OUT*OW-1:0] snap;
        snap = out_flat;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_flat !== snap) begin
            fails++;
            $display("FAIL %s release: out_valid=%0b in_ready=%0b out=%h want 0 1 %h",
                     name, out_valid, in_ready, out_flat, snap);
        end
    endtask

    task automatic run_job(input string name);
        start_job();
        wait_done(name);
        check_out(name);
        release_out(name);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_flat !== '0) begin
            fails++; $display("FAIL reset: in_ready=%0b out_valid=%0b out=%h want 0 0 0", in_ready, out_valid, out_flat);
        end
        rst_n = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL reset_release: in_ready=%0b out_valid=%0b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_fixed();
        fill(1, 1, 1, 1'b0);
        run_job("ones");
        tests++;
        if (got(0) !== 16 || got(1) !== 16) begin
            fails++; $display("FAIL ones_const: got %0d %0d want 16 16", got(0), got(1));
        end
        fill(1, -1, 7, 1'b0);
        run_job("relu");
        tests++;
        if (got(0) !== 0 || got(1) !== 0) begin
            fails++; $display("FAIL relu_const: got %0d %0d want 0 0", got(0), got(1));
        end
        fill(-16, -16, 15, 1'b0);
        run_job("sat_pos");
        tests++;
        if (got(0) !== 61380 || got12(0) !== 2047) begin
            fails++; $display("FAIL sat_pos_const: got %0d %0d want 61380 2047", got(0), got12(0));
        end
        fill(-16, -16, -16, 1'b0);
        run_job("sat_neg");
        tests++;
        if (got(1) !== -65472 || got12(1) !== -2048) begin
            fails++; $display("FAIL sat_neg_const: got %0d %0d want -65472 -2048", got(1), got12(1));
        end
    endtask

    task automatic test_hold();
        logic [N_OUT*OW-1:0] snap;
        int bad = 0;
        fill(0, 0, 0, 1'b1);
        start_job();
        wait_done("hold");
        snap = out_flat;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_flat !== snap || in_ready !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        tests++;
        if (bad != 0) begin fails++; $display("FAIL hold_stable: %0d bad cycles want 0", bad); end
        check_out("hold");
        release_out("hold");
        fill(0, 0, 0, 1'b1);
        run_job("back_to_back");
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            fill(0, 0, 0, 1'b1);
            run_job("random");
        end
    endtask

    task automatic test_reset_mid();
        fill(0, 0, 0, 1'b1);
        start_job();
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b0 || out_flat !== '0 || in_ready !== 1'b0) begin
            fails++; $display("FAIL reset_mid: out_valid=%0b out=%h in_ready=%0b want 0 0 0", out_valid, out_flat, in_ready);
        end
        rst_n = 1'b1;
        repeat (LAT + 5) begin
            @(posedge clk); #1;
            if (out_valid) break;
        end
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_abort: out_valid=%0b in_ready=%0b want 0 1", out_valid, in_ready);
        end
        fill(0, 0, 0, 1'b1);
        run_job("after_reset");
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_hold();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
